// File: rtl/nabp_mapper_pkg.sv
// Shared state type, default accumulator geometry and the line range check
// used by every mapper lane.
package nabp_mapper_pkg;

  typedef enum logic [1:0] {
    READY = 2'd0,
    MAP   = 2'd1,
    FLUSH = 2'd2
  } map_state_e;

  localparam int ACCU_I_DEF = 11;
  localparam int ACCU_F_DEF = 12;
  localparam int ACCU_W     = ACCU_I_DEF + ACCU_F_DEF;

  // True when a signed fixed-point accumulator lands on the projection line.
  function automatic logic in_line(input longint accu, input int line_size, input int frac_w);
    return (accu >= 0) && (accu < (longint'(line_size) << frac_w));
  endfunction

endpackage

// File: rtl/nabp_mapper_lane.sv
// One mapper lane: signed accumulator plus registered, range-checked address.
// With NABP_MAPPER_FRAC_EN the fraction bits are registered alongside.
module nabp_mapper_lane
  import nabp_mapper_pkg::*;
#(
  parameter int AW        = ACCU_W,
  parameter int FRAC      = ACCU_F_DEF,
  parameter int S_W       = 9,
  parameter int LINE_SIZE = 256
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           out_en_i,
  input  logic [AW-1:0]  init_i,
  input  logic [AW-1:0]  base_i,
  output logic [S_W-1:0] s_o,
  output logic           valid_o
`ifdef NABP_MAPPER_FRAC_EN
  ,
  output logic [FRAC-1:0] frac_o
`endif
);

  logic signed [AW-1:0] accu_q, accu_d;
  logic [S_W-1:0]       s_d;
  logic                 valid_d;

  always_comb begin
    accu_d = accu_q;
    if (load_i)      accu_d = init_i;
    else if (step_i) accu_d = accu_q + base_i;
  end

  // Invalid lanes drive zero so downstream RAM ports see a benign address.
  always_comb begin
    valid_d = out_en_i && in_line(longint'(accu_q), LINE_SIZE, FRAC);
    s_d     = valid_d ? accu_q[FRAC +: S_W] : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accu_q  <= '0;
      s_o     <= '0;
      valid_o <= 1'b0;
    end else begin
      accu_q  <= accu_d;
      s_o     <= s_d;
      valid_o <= valid_d;
    end
  end

`ifdef NABP_MAPPER_FRAC_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frac_o <= '0;
    else          frac_o <= valid_d ? accu_q[FRAC-1:0] : '0;
  end
`endif

endmodule

// File: rtl/nabp_multi_mapper.sv
// N_CH-lane NABP mapper: pass FSM, saturating step counter and lane array.
// Optional rm_s_frac port is enabled by NABP_MAPPER_FRAC_EN.
module nabp_multi_mapper
  import nabp_mapper_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int LINE_SIZE = 256,
  parameter int S_W       = 9,
  parameter int ACCU_I    = ACCU_I_DEF,
  parameter int ACCU_F    = ACCU_F_DEF,
  localparam int AW       = ACCU_I + ACCU_F
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_CH*AW-1:0]   mp_accu_init,
  input  logic [N_CH*AW-1:0]   mp_accu_base,
  input  logic                 sh_kick,
  input  logic                 sh_shift_en,
  input  logic                 sh_done,
  output logic                 sh_ack,
  output logic [S_W-1:0]       mp_step_cnt,
  output logic [N_CH*S_W-1:0]  rm_s_val,
  output logic [N_CH-1:0]      rm_s_valid
`ifdef NABP_MAPPER_FRAC_EN
  ,
  output logic [N_CH*ACCU_F-1:0] rm_s_frac
`endif
);

  map_state_e state_q, state_d;
  logic [S_W-1:0] cnt_q, cnt_d;
  logic load, step, out_en;
  logic [N_CH-1:0][S_W-1:0] s_lane;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= READY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      READY:   if (sh_kick) state_d = MAP;
      MAP:     if (sh_done) state_d = FLUSH;
      FLUSH:   state_d = READY;
      default: state_d = READY;
    endcase
  end

  // Lanes reload while idle; outputs keep tracking through FLUSH so the final step is seen.
  always_comb begin
    sh_ack = (state_q == MAP);
    load   = (state_q == READY);
    step   = (state_q == MAP) && sh_shift_en;
    out_en = (state_q != READY);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == READY && sh_kick) cnt_d = '0;
    else if (step && cnt_q != '1)    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign mp_step_cnt = cnt_q;
  assign rm_s_val    = s_lane;

`ifdef NABP_MAPPER_FRAC_EN
  logic [N_CH-1:0][ACCU_F-1:0] f_lane;
  assign rm_s_frac = f_lane;
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    nabp_mapper_lane #(
      .AW       (AW),
      .FRAC     (ACCU_F),
      .S_W      (S_W),
      .LINE_SIZE(LINE_SIZE)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (load),
      .step_i  (step),
      .out_en_i(out_en),
      .init_i  (mp_accu_init[k*AW +: AW]),
      .base_i  (mp_accu_base[k*AW +: AW]),
      .s_o     (s_lane[k]),
      .valid_o (rm_s_valid[k])
`ifdef NABP_MAPPER_FRAC_EN
      ,
      .frac_o  (f_lane[k])
`endif
    );
  end

endmodule

// File: tb/tb_nabp_multi_mapper.sv
// Self-checking bench for nabp_multi_mapper: table-driven first pass, hand-written
// corner sequences, then randomized passes against a cycle-level arithmetic model.
module tb_nabp_multi_mapper;

  localparam int     N    = 4;
  localparam int     S_W  = 9;
  localparam int     AF   = 12;
  localparam int     AW   = 23;
  localparam int     LINE = 256;
  localparam longint ONE  = 4096;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sh_kick = 1'b0, sh_shift_en = 1'b0, sh_done = 1'b0;
  logic [N*AW-1:0] mp_accu_init = '0, mp_accu_base = '0;
  logic sh_ack;
  logic [S_W-1:0] mp_step_cnt;
  logic [N*S_W-1:0] rm_s_val;
  logic [N-1:0] rm_s_valid;
`ifdef NABP_MAPPER_FRAC_EN
  logic [N*AF-1:0] rm_s_frac;
`endif

  nabp_multi_mapper dut (
    .clk(clk), .reset_n(reset_n),
    .mp_accu_init(mp_accu_init), .mp_accu_base(mp_accu_base),
    .sh_kick(sh_kick), .sh_shift_en(sh_shift_en), .sh_done(sh_done),
    .sh_ack(sh_ack), .mp_step_cnt(mp_step_cnt),
    .rm_s_val(rm_s_val), .rm_s_valid(rm_s_valid)
`ifdef NABP_MAPPER_FRAC_EN
    , .rm_s_frac(rm_s_frac)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  longint init_v[N], base_v[N];

  // Reference model: pass phase (0 idle, 1 mapping, 2 flushing), real-valued
  // accumulators in units of 2^-12, and what each lane should be presenting.
  int     m_mode, m_cnt;
  longint m_acc[N], m_s[N], m_fr[N];
  bit     m_v[N];

  function automatic longint wrap(input longint x);
    longint m;
    m = x & ((longint'(1) << AW) - 1);
    if (m >= (longint'(1) << (AW - 1))) m -= (longint'(1) << AW);
    return m;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0;
    for (int k = 0; k < N; k++) begin
      m_acc[k] = 0; m_s[k] = 0; m_fr[k] = 0; m_v[k] = 0;
    end
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      if (m_mode != 0 && m_acc[k] >= 0 && m_acc[k] < LINE * ONE) begin
        m_v[k] = 1; m_s[k] = m_acc[k] / ONE; m_fr[k] = m_acc[k] % ONE;
      end else begin
        m_v[k] = 0; m_s[k] = 0; m_fr[k] = 0;
      end
    end
    case (m_mode)
      0: begin
        for (int k = 0; k < N; k++) m_acc[k] = wrap(init_v[k]);
        if (sh_kick) begin m_mode = 1; m_cnt = 0; end
      end
      1: begin
        if (sh_shift_en) begin
          for (int k = 0; k < N; k++) m_acc[k] = wrap(m_acc[k] + base_v[k]);
          if (m_cnt < (1 << S_W) - 1) m_cnt++;
        end
        if (sh_done) m_mode = 2;
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic apply_lanes();
    for (int k = 0; k < N; k++) begin
      mp_accu_init[k*AW +: AW] = init_v[k][AW-1:0];
      mp_accu_base[k*AW +: AW] = base_v[k][AW-1:0];
    end
  endtask

  task automatic drive(input bit kick, input bit shift, input bit done);
    sh_kick = kick; sh_shift_en = shift; sh_done = done;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " ack"}, longint'(sh_ack), longint'(m_mode == 1));
    chk({tag, " cnt"}, longint'(mp_step_cnt), longint'(m_cnt));
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s s[%0d]", tag, k), longint'(rm_s_val[k*S_W +: S_W]), m_s[k]);
      chk($sformatf("%s valid[%0d]", tag, k), longint'(rm_s_valid[k]), longint'(m_v[k]));
`ifdef NABP_MAPPER_FRAC_EN
      chk($sformatf("%s frac[%0d]", tag, k), longint'(rm_s_frac[k*AF +: AF]), m_fr[k]);
`endif
    end
  endtask

  task automatic expect_lane(input string tag, input int k, input longint s, input bit v);
    chk($sformatf("%s s[%0d]", tag, k), longint'(rm_s_val[k*S_W +: S_W]), s);
    chk($sformatf("%s valid[%0d]", tag, k), longint'(rm_s_valid[k]), longint'(v));
  endtask

  task automatic set_all(input longint init, input longint base);
    for (int k = 0; k < N; k++) begin init_v[k] = init; base_v[k] = base; end
    apply_lanes();
  endtask

  typedef struct {
    bit kick, shift, done;
    bit ack;
    int cnt;
    int s;
    bit v;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // First pass: init 0, step 1.0, five shifts; outputs lag the accumulator by one edge.
    tbl[0] = '{1, 0, 0, 1, 0, 0, 0};
    tbl[1] = '{0, 1, 0, 1, 1, 0, 1};
    tbl[2] = '{0, 1, 0, 1, 2, 1, 1};
    tbl[3] = '{0, 1, 0, 1, 3, 2, 1};
    tbl[4] = '{0, 1, 0, 1, 4, 3, 1};
    tbl[5] = '{0, 1, 0, 1, 5, 4, 1};
    tbl[6] = '{0, 0, 0, 1, 5, 5, 1};
    tbl[7] = '{0, 0, 1, 0, 5, 5, 1};
    tbl[8] = '{0, 0, 0, 0, 5, 5, 1};
    tbl[9] = '{0, 0, 0, 0, 5, 0, 0};

    model_reset();
    set_all(0, ONE);
    #2;
    check_model("reset");
    #10 reset_n = 1'b1;
    cyc();
    check_model("idle");

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].kick, tbl[i].shift, tbl[i].done);
      cyc();
      chk($sformatf("tbl%0d ack", i), longint'(sh_ack), longint'(tbl[i].ack));
      chk($sformatf("tbl%0d cnt", i), longint'(mp_step_cnt), longint'(tbl[i].cnt));
      for (int k = 0; k < N; k++) expect_lane($sformatf("tbl%0d", i), k, tbl[i].s, tbl[i].v);
    end
    drive(0, 0, 0);

    // Negative start crossing zero, and a lane running off the top of the line.
    init_v[0] = -10240;    base_v[0] = ONE;
    init_v[1] = 254 * ONE; base_v[1] = ONE;
    init_v[2] = 0;         base_v[2] = 0;
    init_v[3] = 0;         base_v[3] = 0;
    apply_lanes();
    drive(1, 1, 0); cyc(); check_model("edge kick");
    drive(0, 1, 0);
    cyc(); check_model("edge s1"); expect_lane("edge s1", 1, 254, 1); expect_lane("edge s1", 0, 0, 0);
    cyc(); check_model("edge s2"); expect_lane("edge s2", 1, 255, 1); expect_lane("edge s2", 0, 0, 0);
    cyc(); check_model("edge s3"); expect_lane("edge s3", 1, 0, 0);   expect_lane("edge s3", 0, 0, 0);
    cyc(); check_model("edge s4"); expect_lane("edge s4", 0, 0, 1);
    cyc(); check_model("edge s5"); expect_lane("edge s5", 0, 1, 1);
    drive(0, 0, 1); cyc(); check_model("edge done");
    drive(0, 0, 0); cyc(); check_model("edge flush"); cyc(); check_model("edge ready");

    // Independent lanes with mixed step signs.
    for (int k = 0; k < N; k++) init_v[k] = 3 * ONE;
    base_v[0] = ONE / 2; base_v[1] = ONE; base_v[2] = -ONE; base_v[3] = ONE / 4;
    apply_lanes();
    drive(1, 0, 0); cyc(); check_model("lanes kick");
    drive(0, 1, 0);
    for (int i = 0; i < 8; i++) begin cyc(); check_model($sformatf("lanes s%0d", i)); end
    drive(0, 0, 0); cyc(); check_model("lanes hold");
    expect_lane("lanes end", 0, 7, 1);
    expect_lane("lanes end", 1, 11, 1);
    expect_lane("lanes end", 2, 0, 0);
    expect_lane("lanes end", 3, 5, 1);
    drive(0, 0, 1); cyc(); drive(0, 0, 0); cyc(); cyc(); check_model("lanes ready");

    // Done coincident with a shift, then a kick landing in FLUSH.
    set_all(10 * ONE, ONE);
    drive(1, 0, 0); cyc();
    drive(0, 1, 0); cyc(); cyc();
    drive(0, 1, 1); cyc(); check_model("dsh done");
    chk("dsh flush ack", longint'(sh_ack), 0);
    chk("dsh cnt", longint'(mp_step_cnt), 3);
    expect_lane("dsh flush", 0, 12, 1);
    drive(1, 0, 0); cyc(); check_model("dsh kick-in-flush");
    expect_lane("dsh final", 0, 13, 1);
    chk("dsh ready ack", longint'(sh_ack), 0);
    drive(0, 0, 0); cyc(); check_model("dsh after");
    chk("dsh ignored kick ack", longint'(sh_ack), 0);
    expect_lane("dsh after", 0, 0, 0);

    // Asynchronous reset between edges in the middle of a pass.
    set_all(5 * ONE, ONE);
    drive(1, 0, 0); cyc();
    drive(0, 1, 0); cyc(); cyc(); cyc();
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_model("async rst");
    chk("async rst ack", longint'(sh_ack), 0);
    @(posedge clk); #1;
    check_model("rst held");
    drive(0, 0, 0);
    #2 reset_n = 1'b1;
    cyc(); check_model("post rst");
    drive(1, 1, 0); cyc(); check_model("post rst kick");
    drive(0, 1, 0); cyc(); check_model("post rst s1");
    expect_lane("post rst s1", 0, 5, 1);
    drive(0, 0, 1); cyc(); drive(0, 0, 0); cyc(); cyc();

`ifdef NABP_MAPPER_FRAC_EN
    // Quarter steps walk the fraction through its four phases.
    set_all(0, ONE / 4);
    drive(1, 0, 0); cyc();
    drive(0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(); check_model($sformatf("frac s%0d", i));
      chk($sformatf("frac phase%0d", i), longint'(rm_s_frac[AF-1:0]), longint'((i % 4) * 1024));
      chk($sformatf("frac int%0d", i), longint'(rm_s_val[S_W-1:0]), longint'(i / 4));
    end
    drive(0, 0, 1); cyc(); drive(0, 0, 0); cyc(); cyc();
`endif

    // Step counter saturates at all-ones.
    set_all(10 * ONE, 0);
    drive(1, 0, 0); cyc();
    drive(0, 1, 0);
    for (int i = 0; i < 515; i++) cyc();
    check_model("sat");
    chk("sat cnt", longint'(mp_step_cnt), 511);
    drive(0, 0, 1); cyc(); drive(0, 0, 0); cyc(); cyc();

    // Randomized passes.
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < N; k++) begin
        init_v[k] = longint'($urandom_range(0, 320 * 4096)) - 20 * ONE;
        base_v[k] = longint'($urandom_range(0, 4 * 4096)) - 2 * ONE;
      end
      apply_lanes();
      for (int c = 0; c < 40; c++) begin
        drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        cyc();
        check_model($sformatf("rnd p%0d c%0d", p, c));
      end
      drive(0, 0, 1); cyc(); drive(0, 0, 0); cyc(); cyc();
      check_model($sformatf("rnd p%0d end", p));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
